datapath_controller: RTL and testbench

Multi-cycle sequencer that drives the 16-bit function unit and its register file. It accepts one encoded instruction at a time over a valid/ready handshake. It then issues the register addresses, function select, operand-B source select and write enable in a fixed state sequence. Finally it latches the function unit's V/C/N/Z flags into a status register and pulses completion.

---
 rtl/datapath_controller.sv | 127 ++++++++++++
 tb/tb_datapath_controller.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/datapath_controller.sv
`default_nettype none
// ============================================================================
// Module   : datapath_controller
// Brief    : Four-state sequencer (IDLE/READ/EXEC/DONE) driving the 16-bit
//            function unit and register file from one encoded instruction.
//            Optional macro DPC_FLAGS_EN builds the V/C/N/Z status register.
// Revision : 1.0 - initial release
// ============================================================================
module datapath_controller #(
    parameter int REG_ADDR_W = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [15:0]           instr,
    input  logic                  fu_v,
    input  logic                  fu_c,
    input  logic                  fu_n,
    input  logic                  fu_z,
    output logic [3:0]            fs,
    output logic [REG_ADDR_W-1:0] da,
    output logic [REG_ADDR_W-1:0] aa,
    output logic [REG_ADDR_W-1:0] ba,
    output logic                  mb,
    output logic [15:0]           imm,
    output logic                  rw,
    output logic                  done,
    output logic                  err,
    output logic [3:0]            status
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [3:0] c_OP_LDI     = 4'hD;
    localparam logic [3:0] c_OP_NOP     = 4'hE;
    localparam logic [3:0] c_OP_ILLEGAL = 4'hF;
    localparam logic [3:0] c_FS_LOAD    = 4'hC;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_instr;
    logic [3:0]  w_op;
    logic        w_writes;

    assign w_op     = r_instr[15:12];
    assign w_writes = (w_op <= c_OP_LDI);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_instr <= 16'h0000;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE && instr_valid)
                r_instr <= instr;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (instr_valid) w_state_nxt = S_READ;
            S_READ:  w_state_nxt = S_EXEC;
            S_EXEC:  w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Strobes are gated by rst so an aborted instruction never writes or completes.
    always_comb begin
        fs   = 4'h0;
        mb   = 1'b0;
        rw   = 1'b0;
        done = 1'b0;
        err  = 1'b0;
        if (r_state == S_READ || r_state == S_EXEC) begin
            case (w_op)
                c_OP_LDI: begin
                    fs = c_FS_LOAD;
                    mb = 1'b1;
                end
                c_OP_NOP, c_OP_ILLEGAL: fs = 4'h0;
                default:                fs = w_op;
            endcase
        end
        if (r_state == S_EXEC && w_writes && !rst)
            rw = 1'b1;
        if (r_state == S_DONE && !rst) begin
            done = 1'b1;
            err  = (w_op == c_OP_ILLEGAL);
        end
    end

    assign instr_ready = (r_state == S_IDLE);
    assign da  = REG_ADDR_W'(r_instr[11:9]);
    assign aa  = REG_ADDR_W'(r_instr[8:6]);
    assign ba  = REG_ADDR_W'(r_instr[5:3]);
    assign imm = {13'b0, r_instr[2:0]};

`ifdef DPC_FLAGS_EN
    logic [3:0] r_status;

    // NOP and illegal opcodes leave the flags untouched.
    always_ff @(posedge clk) begin
        if (rst)
            r_status <= 4'b0000;
        else if (r_state == S_EXEC && w_writes)
            r_status <= {fu_v, fu_c, fu_n, fu_z};
    end

    assign status = r_status;
`else
    logic w_unused_flags;

    assign w_unused_flags = &{fu_v, fu_c, fu_n, fu_z};
    assign status         = 4'b0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_datapath_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_datapath_controller
// Brief    : Directed self-checking bench for datapath_controller.
// Revision : 1.0 - initial release
// ============================================================================
module tb_datapath_controller;

    logic        clk;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic        fu_v, fu_c, fu_n, fu_z;
    logic [3:0]  fs;
    logic [2:0]  da, aa, ba;
    logic        mb;
    logic [15:0] imm;
    logic        rw;
    logic        done;
    logic        err;
    logic [3:0]  status;

    int errors;
    int checks;

    datapath_controller #(.REG_ADDR_W(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .fu_v        (fu_v),
        .fu_c        (fu_c),
        .fu_n        (fu_n),
        .fu_z        (fu_z),
        .fs          (fs),
        .da          (da),
        .aa          (aa),
        .ba          (ba),
        .mb          (mb),
        .imm         (imm),
        .rw          (rw),
        .done        (done),
        .err         (err),
        .status      (status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef DPC_FLAGS_EN
    function automatic logic [3:0] flags_exp(input logic [3:0] f);
        return f;
    endfunction
`else
    function automatic logic [3:0] flags_exp(input logic [3:0] f);
        return 4'b0000 & f;
    endfunction
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fu(input logic [3:0] f);
        {fu_v, fu_c, fu_n, fu_z} = f;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        instr_valid = 1'b0;
        instr = 16'h0000;
        set_fu(4'b0000);
        tick();
        tick();
        rst = 1'b0;
        tick();
        checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", instr_ready); end
        checks++; if ({rw, done, err} !== 3'b000) begin errors++; $display("FAIL reset_strobes got=%b exp=000", {rw, done, err}); end
        checks++; if (status !== 4'b0000) begin errors++; $display("FAIL reset_status got=%b exp=0000", status); end
        checks++; if ({fs, mb} !== 5'b0) begin errors++; $display("FAIL reset_fs_mb got=%b exp=00000", {fs, mb}); end
    endtask

    task automatic test_add();
        instr = 16'h2298;
        instr_valid = 1'b1;
        set_fu(4'b0101);
        tick();
        instr_valid = 1'b0;
        checks++; if ({fs, da, aa, ba} !== {4'b0010, 3'd1, 3'd2, 3'd3}) begin errors++; $display("FAIL add_read_fields got=%h/%0d/%0d/%0d exp=2/1/2/3", fs, da, aa, ba); end
        checks++; if ({mb, rw, instr_ready} !== 3'b000) begin errors++; $display("FAIL add_read_ctl got=%b exp=000", {mb, rw, instr_ready}); end
        tick();
        checks++; if ({rw, fs} !== {1'b1, 4'b0010}) begin errors++; $display("FAIL add_exec got=%b exp=10010", {rw, fs}); end
        tick();
        checks++; if ({done, err, rw, fs} !== {1'b1, 1'b0, 1'b0, 4'b0000}) begin errors++; $display("FAIL add_done got=%b exp=1000000", {done, err, rw, fs}); end
        checks++; if (status !== flags_exp(4'b0101)) begin errors++; $display("FAIL add_status got=%b exp=%b", status, flags_exp(4'b0101)); end
        tick();
        checks++; if ({instr_ready, done} !== 2'b10) begin errors++; $display("FAIL add_idle got=%b exp=10", {instr_ready, done}); end
    endtask

    task automatic test_ldi();
        instr = 16'hD805;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        checks++; if ({fs, mb, imm, da, rw} !== {4'b1100, 1'b1, 16'h0005, 3'd4, 1'b0}) begin errors++; $display("FAIL ldi_read got=%h/%b/%h/%0d/%b exp=c/1/0005/4/0", fs, mb, imm, da, rw); end
        tick();
        checks++; if ({rw, mb, fs} !== {1'b1, 1'b1, 4'b1100}) begin errors++; $display("FAIL ldi_exec got=%b exp=111100", {rw, mb, fs}); end
        tick();
        checks++; if ({rw, done, mb} !== 3'b010) begin errors++; $display("FAIL ldi_done got=%b exp=010", {rw, done, mb}); end
        tick();
        checks++; if (rw !== 1'b0) begin errors++; $display("FAIL ldi_after got=%b exp=0", rw); end
    endtask

    task automatic test_illegal();
        logic saw_rw;
        saw_rw = 1'b0;
        instr = 16'hF000;
        instr_valid = 1'b1;
        set_fu(4'b1010);
        tick();
        instr_valid = 1'b0;
        saw_rw |= rw;
        tick();
        saw_rw |= rw;
        tick();
        saw_rw |= rw;
        checks++; if ({done, err} !== 2'b11) begin errors++; $display("FAIL ill_done_err got=%b exp=11", {done, err}); end
        checks++; if (status !== flags_exp(4'b0101)) begin errors++; $display("FAIL ill_status got=%b exp=%b", status, flags_exp(4'b0101)); end
        tick();
        checks++; if (saw_rw !== 1'b0) begin errors++; $display("FAIL ill_rw got=%b exp=0", saw_rw); end
        checks++; if ({done, err} !== 2'b00) begin errors++; $display("FAIL ill_pulse_width got=%b exp=00", {done, err}); end
    endtask

    task automatic test_nop();
        logic saw_rw;
        saw_rw = 1'b0;
        instr = 16'hE000;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        saw_rw |= rw;
        checks++; if (fs !== 4'b0000) begin errors++; $display("FAIL nop_fs got=%b exp=0000", fs); end
        tick();
        saw_rw |= rw;
        tick();
        saw_rw |= rw;
        checks++; if ({done, err, saw_rw} !== 3'b100) begin errors++; $display("FAIL nop_done got=%b exp=100", {done, err, saw_rw}); end
        checks++; if (status !== flags_exp(4'b0101)) begin errors++; $display("FAIL nop_status got=%b exp=%b", status, flags_exp(4'b0101)); end
        tick();
    endtask

    task automatic test_back_to_back();
        int n;
        set_fu(4'b0101);
        instr = 16'h2298;
        instr_valid = 1'b1;
        checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready0 got=%b exp=1", instr_ready); end
        tick();
        instr = 16'h1200;
        n = 0;
        while (!instr_ready && n < 8) begin
            tick();
            n++;
        end
        checks++; if (n !== 3) begin errors++; $display("FAIL b2b_gap got=%0d exp=3 cycles to ready", n); end
        tick();
        checks++; if ({instr_ready, fs, da, aa} !== {1'b0, 4'b0001, 3'd1, 3'd0}) begin errors++; $display("FAIL b2b_read2 got=%b/%h/%0d/%0d exp=0/1/1/0", instr_ready, fs, da, aa); end
        instr_valid = 1'b0;
        tick();
        checks++; if ({rw, fs, da, aa} !== {1'b1, 4'b0001, 3'd1, 3'd0}) begin errors++; $display("FAIL b2b_exec2 got=%b/%h/%0d/%0d exp=1/1/1/0", rw, fs, da, aa); end
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        set_fu(4'b1111);
        instr = 16'h2298;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        tick();
        checks++; if (rw !== 1'b1) begin errors++; $display("FAIL rmid_exec_rw got=%b exp=1", rw); end
        rst = 1'b1;
        #1;
        checks++; if ({rw, done, err} !== 3'b000) begin errors++; $display("FAIL rmid_gated got=%b exp=000", {rw, done, err}); end
        tick();
        rst = 1'b0;
        checks++; if ({instr_ready, done, rw} !== 3'b100) begin errors++; $display("FAIL rmid_idle got=%b exp=100", {instr_ready, done, rw}); end
        checks++; if (status !== 4'b0000) begin errors++; $display("FAIL rmid_status got=%b exp=0000", status); end
        tick();
        checks++; if ({done, rw, instr_ready} !== 3'b001) begin errors++; $display("FAIL rmid_nodone got=%b exp=001", {done, rw, instr_ready}); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_add();
        test_ldi();
        test_illegal();
        test_nop();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
